// File: rtl/load_use_hazard_scoreboard.sv
// Load-use hazard scoreboard: per-register load latency tracking,
// stall/flush arbitration and a saturating stall-cycle counter.
module load_use_hazard_scoreboard #(
    parameter int REG_ADDR_W   = 4,
    parameter int NUM_SRC      = 2,
    parameter int LOAD_LATENCY = 2,
    parameter int ZERO_REG_EN  = 1,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_decode,
    input  logic [NUM_SRC-1:0]            rs_valid_decode,
    input  logic [REG_ADDR_W-1:0]         rd_execute,
    input  logic                          reg_write_execute,
    input  logic                          mem_read_execute,
    input  logic                          branch_taken_execute,
    input  logic                          stall_count_clr,
    output logic                          stall_decode,
    output logic                          bubble_execute,
    output logic                          flush_fetch_decode,
    output logic [2**REG_ADDR_W-1:0]      pending_mask,
    output logic [STALL_CNT_W-1:0]        stall_count
);
    localparam int NREG = 2**REG_ADDR_W;
    localparam int CW   = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(LOAD_LATENCY - 1);

    logic [CW-1:0]         cnt_q [NREG];
    logic [CW-1:0]         cnt_d [NREG];
    logic [NREG-1:0]       mask_d;
    logic                  zero_rd;
    logic                  issue;
    logic                  hazard;
    logic [REG_ADDR_W-1:0] rs;

    assign zero_rd = (ZERO_REG_EN != 0) && (rd_execute == '0);
    assign issue   = mem_read_execute & reg_write_execute & ~zero_rd;

    // A fresh issue overrides any residual count for the same register.
    always_comb begin
        mask_d = '0;
        for (int r = 0; r < NREG; r++) begin
            if (issue && rd_execute == REG_ADDR_W'(r))
                cnt_d[r] = RELOAD;
            else if (cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - 1'b1;
            else
                cnt_d[r] = '0;
            mask_d[r] = (cnt_d[r] != '0);
        end
    end

    always_comb begin
        hazard = 1'b0;
        rs     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs = rs_decode[i*REG_ADDR_W +: REG_ADDR_W];
            if (rs_valid_decode[i]
                && !((ZERO_REG_EN != 0) && rs == '0)
                && ((issue && rs == rd_execute) || cnt_q[rs] != '0))
                hazard = 1'b1;
        end
    end

    // Flush wins: the stalled consumer is squashed anyway.
    assign flush_fetch_decode = branch_taken_execute;
    assign stall_decode       = hazard & ~branch_taken_execute;
    assign bubble_execute     = hazard & ~branch_taken_execute;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++)
                cnt_q[r] <= '0;
            pending_mask <= '0;
        end else begin
            for (int r = 0; r < NREG; r++)
                cnt_q[r] <= cnt_d[r];
            pending_mask <= mask_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall_count_clr)
            stall_count <= '0;
        else if (stall_decode && !(&stall_count))
            stall_count <= stall_count + 1'b1;
    end
endmodule

// File: tb/tb_load_use_hazard_scoreboard.sv
// Directed bench for load_use_hazard_scoreboard: default, single-cycle
// latency and narrow stall counter configurations driven in parallel.
module tb_load_use_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rs_decode;
    logic [1:0]  rs_valid_decode;
    logic [3:0]  rd_execute;
    logic        reg_write_execute;
    logic        mem_read_execute;
    logic        branch_taken_execute;
    logic        stall_count_clr;

    logic        st0, bb0, fl0;
    logic [15:0] pm0, sc0;
    logic        st1, bb1, fl1;
    logic [15:0] pm1, sc1;
    logic        st2, bb2, fl2;
    logic [15:0] pm2;
    logic [1:0]  sc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_use_hazard_scoreboard d0 (
        .clk(clk), .rst_n(rst_n),
        .rs_decode(rs_decode), .rs_valid_decode(rs_valid_decode),
        .rd_execute(rd_execute), .reg_write_execute(reg_write_execute),
        .mem_read_execute(mem_read_execute),
        .branch_taken_execute(branch_taken_execute),
        .stall_count_clr(stall_count_clr),
        .stall_decode(st0), .bubble_execute(bb0),
        .flush_fetch_decode(fl0), .pending_mask(pm0), .stall_count(sc0)
    );

    load_use_hazard_scoreboard #(.LOAD_LATENCY(1)) d1 (
        .clk(clk), .rst_n(rst_n),
        .rs_decode(rs_decode), .rs_valid_decode(rs_valid_decode),
        .rd_execute(rd_execute), .reg_write_execute(reg_write_execute),
        .mem_read_execute(mem_read_execute),
        .branch_taken_execute(branch_taken_execute),
        .stall_count_clr(stall_count_clr),
        .stall_decode(st1), .bubble_execute(bb1),
        .flush_fetch_decode(fl1), .pending_mask(pm1), .stall_count(sc1)
    );

    load_use_hazard_scoreboard #(.STALL_CNT_W(2)) d2 (
        .clk(clk), .rst_n(rst_n),
        .rs_decode(rs_decode), .rs_valid_decode(rs_valid_decode),
        .rd_execute(rd_execute), .reg_write_execute(reg_write_execute),
        .mem_read_execute(mem_read_execute),
        .branch_taken_execute(branch_taken_execute),
        .stall_count_clr(stall_count_clr),
        .stall_decode(st2), .bubble_execute(bb2),
        .flush_fetch_decode(fl2), .pending_mask(pm2), .stall_count(sc2)
    );

    task automatic drive(input logic [3:0] s0, input logic [3:0] s1,
                         input logic [1:0] v, input logic [3:0] rd,
                         input logic ld, input logic br);
        rs_decode            = {s1, s0};
        rs_valid_decode      = v;
        rd_execute           = rd;
        reg_write_execute    = ld;
        mem_read_execute     = ld;
        branch_taken_execute = br;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall_count_clr = 1'b0;
        drive(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
        #2;
        checks++;
        if ({st0, bb0, fl0} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outs got %b want 000", {st0, bb0, fl0});
        end
        checks++;
        if (pm0 !== 16'h0 || sc0 !== 16'h0 || sc2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got pm=%h sc=%h sc2=%h want 0",
                     pm0, sc0, sc2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_default_latency();
        drive(4'd5, 4'd0, 2'b01, 4'd5, 1'b1, 1'b0);
        checks++;
        if ({st0, bb0, st1, bb1} !== 4'b1111) begin
            errors++;
            $display("FAIL lat_c1 got %b want 1111", {st0, bb0, st1, bb1});
        end
        step();
        drive(4'd5, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0);
        checks++;
        if (st0 !== 1'b1 || pm0 !== 16'h0020) begin
            errors++;
            $display("FAIL lat_c2_d0 got st=%b pm=%h want 1 0020", st0, pm0);
        end
        checks++;
        if (st1 !== 1'b0 || pm1 !== 16'h0) begin
            errors++;
            $display("FAIL lat_c2_ll1 got st=%b pm=%h want 0 0000", st1, pm1);
        end
        step();
        checks++;
        if (st0 !== 1'b0 || st1 !== 1'b0 || pm0 !== 16'h0) begin
            errors++;
            $display("FAIL lat_c3 got st0=%b st1=%b pm=%h want 0 0 0000",
                     st0, st1, pm0);
        end
        checks++;
        if (sc0 !== 16'd2 || sc1 !== 16'd1) begin
            errors++;
            $display("FAIL lat_count got sc0=%0d sc1=%0d want 2 1", sc0, sc1);
        end
        drive(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_zero_and_valid();
        drive(4'd0, 4'd0, 2'b01, 4'd0, 1'b1, 1'b0);
        checks++;
        if (st0 !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg got %b want 0", st0);
        end
        step();
        checks++;
        if (pm0 !== 16'h0) begin
            errors++;
            $display("FAIL zero_mask got %h want 0000", pm0);
        end
        drive(4'd3, 4'd3, 2'b00, 4'd3, 1'b1, 1'b0);
        checks++;
        if (st0 !== 1'b0) begin
            errors++;
            $display("FAIL invalid_src got %b want 0", st0);
        end
        drive(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
        step();
        drive(4'd0, 4'd3, 2'b10, 4'd3, 1'b1, 1'b0);
        checks++;
        if (st0 !== 1'b1 || st1 !== 1'b1) begin
            errors++;
            $display("FAIL src2_hit got %b%b want 11", st0, st1);
        end
        step();
        drive(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
        step();
    endtask

    task automatic test_flush_priority();
        drive(4'd7, 4'd0, 2'b01, 4'd7, 1'b1, 1'b1);
        checks++;
        if ({fl0, st0, bb0} !== 3'b100) begin
            errors++;
            $display("FAIL flush_prio got %b want 100", {fl0, st0, bb0});
        end
        step();
        drive(4'd7, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0);
        checks++;
        if (pm0[7] !== 1'b1 || st0 !== 1'b1 || fl0 !== 1'b0) begin
            errors++;
            $display("FAIL flush_keep got pm7=%b st=%b fl=%b want 1 1 0",
                     pm0[7], st0, fl0);
        end
        step();
        checks++;
        if (st0 !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain got %b want 0", st0);
        end
        drive(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive(4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 1'b0);
        step();
        checks++;
        if (pm0 !== 16'h0010) begin
            errors++;
            $display("FAIL b2b_first got %h want 0010", pm0);
        end
        step();
        drive(4'd4, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0);
        checks++;
        if (pm0 !== 16'h0010 || st0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reload got pm=%h st=%b want 0010 1", pm0, st0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (pm0 !== 16'h0 || st0 !== 1'b0 || sc0 !== 16'h0) begin
            errors++;
            $display("FAIL async_rst got pm=%h st=%b sc=%h want 0 0 0",
                     pm0, st0, sc0);
        end
        #1;
        rst_n = 1'b1;
        drive(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_saturation();
        logic [1:0] exp [5];
        exp[0] = 2'd1; exp[1] = 2'd2; exp[2] = 2'd3;
        exp[3] = 2'd3; exp[4] = 2'd3;
        drive(4'd5, 4'd0, 2'b01, 4'd5, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (sc2 !== exp[i]) begin
                errors++;
                $display("FAIL sat_%0d got %0d want %0d", i, sc2, exp[i]);
            end
        end
        stall_count_clr = 1'b1;
        #1;
        checks++;
        if (st2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_stall got %b want 1", st2);
        end
        step();
        stall_count_clr = 1'b0;
        checks++;
        if (sc2 !== 2'd0 || sc0 !== 16'd0) begin
            errors++;
            $display("FAIL clr_prio got sc2=%0d sc0=%0d want 0 0", sc2, sc0);
        end
        step();
        checks++;
        if (sc2 !== 2'd1) begin
            errors++;
            $display("FAIL clr_resume got %0d want 1", sc2);
        end
        drive(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        test_reset();
        test_default_latency();
        test_zero_and_valid();
        test_flush_priority();
        test_back_to_back();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
